shift_sequencer: RTL

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer_if.sv | 22 ++
 rtl/shift_sequencer.sv | 132 +++++++++++++
 2 files changed

// File: rtl/shift_sequencer_if.sv
// Handshake and operand bundle for shift_sequencer; master issues requests,
// slave (the sequencer) reports status and the shifted result.
interface shift_sequencer_if;
  logic       start;
  logic [7:0] data_in;
  logic [3:0] count;
  logic [1:0] op_type;
  logic       ready;
  logic       busy;
  logic       done;
  logic [7:0] result;

  modport master (
    output start, data_in, count, op_type,
    input  ready, busy, done, result
  );

  modport slave (
    input  start, data_in, count, op_type,
    output ready, busy, done, result
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle 1-bit-per-cycle shifter with IDLE/SHIFT/DONE sequencing.
// Optional rotate support is enabled by defining SHIFT_SEQ_ROTATE_EN.
module shift_sequencer (
  input  logic                clk,
  input  logic                rst,
  shift_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_LOG   = 2'd0,
    MODE_ARITH = 2'd1,
    MODE_ROT   = 2'd2
  } mode_t;

  state_t     state_r;
  mode_t      mode_r;
  logic [7:0] work_r;
  logic [4:0] remaining_r;
  logic       dir_right_r;
  logic [7:0] result_r;
  logic       ready_r;
  logic       busy_r;
  logic       done_r;

  // Magnitude of a 4-bit two's-complement amount; -8 maps to 8.
  function automatic logic [4:0] shift_mag(input logic [3:0] amt);
    logic [4:0] mag;
    if (amt[3]) begin
      mag = {1'b0, ~amt} + 5'd1;
    end else begin
      mag = {1'b0, amt};
    end
    return mag;
  endfunction

  function automatic mode_t decode_mode(input logic [1:0] op);
    mode_t m;
    case (op)
      2'b00:   m = MODE_ARITH;
`ifdef SHIFT_SEQ_ROTATE_EN
      2'b01:   m = MODE_ROT;
`else
      2'b01:   m = MODE_LOG;
`endif
      2'b10:   m = MODE_LOG;
      2'b11:   m = MODE_LOG;
      default: m = MODE_LOG;
    endcase
    return m;
  endfunction

  function automatic logic [7:0] shift_step(input logic [7:0] w, input logic right, input mode_t m);
    logic [7:0] nxt;
    case (m)
      MODE_ARITH: nxt = right ? {w[7], w[7:1]} : {w[6:0], 1'b0};
`ifdef SHIFT_SEQ_ROTATE_EN
      MODE_ROT:   nxt = right ? {w[0], w[7:1]} : {w[6:0], w[7]};
`endif
      MODE_LOG:   nxt = right ? {1'b0, w[7:1]} : {w[6:0], 1'b0};
      default:    nxt = right ? {1'b0, w[7:1]} : {w[6:0], 1'b0};
    endcase
    return nxt;
  endfunction

  // Sequencer state, datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      mode_r      <= MODE_LOG;
      work_r      <= 8'h00;
      remaining_r <= 5'd0;
      dir_right_r <= 1'b0;
      result_r    <= 8'h00;
      ready_r     <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            work_r      <= bus.data_in;
            dir_right_r <= bus.count[3];
            mode_r      <= decode_mode(bus.op_type);
            remaining_r <= shift_mag(bus.count);
            state_r     <= SHIFT;
            ready_r     <= 1'b0;
            busy_r      <= 1'b1;
          end else begin
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
          end
        end
        SHIFT: begin
          if (remaining_r != 5'd0) begin
            work_r      <= shift_step(work_r, dir_right_r, mode_r);
            remaining_r <= remaining_r - 5'd1;
          end else begin
            result_r <= work_r;
            done_r   <= 1'b1;
            state_r  <= DONE;
          end
        end
        DONE: begin
          // A start seen here is deliberately dropped; it must reappear in IDLE.
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          ready_r <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready  = ready_r;
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.result = result_r;

endmodule
